btn_event_scheduler: RTL and testbench
======================================

# btn_event_scheduler

Shared-prescaler button front end for NUM_BTNS buttons. Every button is sampled on one common debounce tick. Each button runs its own press / hold classifier, which yields SHORT and LONG press events. A round-robin arbiter serialises these events onto a single valid/ready event port that the TV-B-Gone mode/sequence controller consumes.

## Interface

**Parameters**
- `NUM_BTNS`, 4: number of buttons, 2..8.
- `PERIOD_MS`, 10: debounce sample period in ms.
- `CLK_MHZ`, 8: clock frequency in MHz. `COUNT_PER_PERIOD = CLK_MHZ*PERIOD_MS*1000`.
- `LONG_PRESS_TICKS`, 100: number of held ticks, counted after the press edge, at which a LONG event is issued. Must be ≥ 2.

**Ports**
- `clock_in`, input, 1: the single clock.
- `reset_in`, input, 1: synchronous, active-low reset.
- `btn_in`, input, `NUM_BTNS`: raw buttons, active-high, already synchronised.
- `event_valid_out`, output, 1: event present.
- `event_ready_in`, input, 1: consumer accepts.
- `event_btn_out`, output, `$clog2(NUM_BTNS)`: button index of the event.
- `event_long_out`, output, 1: 1 = LONG, 0 = SHORT.
- `overrun_out`, output, 1: sticky; an event was lost.

## Operation

**Tick generation**
- One down-counter of width `$clog2(COUNT_PER_PERIOD)`.
- Reset loads `COUNT_PER_PERIOD-1`.
- `tick` is high for one cycle when the counter is 0; the counter then reloads.

**Sampling**
- On `tick`, each button shifts `probe[i] <= {probe[i][1:0], btn_in[i]}`.
- Press edge: `probe[2:0]==3'b011`.
- Released: `probe[1:0]==2'b00`.

**Per-button FSM (IDLE / HELD / LONG)**
- FSM and hold counter update only on `tick`, using the probe value *after* that tick's shift.
- IDLE → HELD on press edge; `hold_cnt <= 0`.
- HELD, not released: `hold_cnt++`. When `hold_cnt == LONG_PRESS_TICKS-1`, post LONG and go to LONG.
- HELD, released: post SHORT, go to IDLE.
- LONG, released: go to IDLE with no event.
- A single low sample, or a single high glitch, never changes state.

**Pending flags**
- Each button has `pend_short[i]` and `pend_long[i]`.
- Posting sets the flag.
- Posting while the flag is already set (and not being cleared in that cycle) sets `overrun_out`. The new event is dropped.

**Arbiter**
- Loads the output register when `!event_valid_out || event_ready_in`.
- Winner: the first button with any pending flag, searching from `rr_ptr` upward and wrapping.
- Within one button, LONG takes precedence over SHORT.
- On load: the winner's chosen flag clears, and `rr_ptr <= winner+1` (mod `NUM_BTNS`).
- If nothing is pending on a load opportunity, `event_valid_out` drops.
- If a load clears a flag in the same cycle a post sets it, the post wins: the flag stays set and no overrun is raised.

**Reset**
- Applies at any time, including mid-hold or while an event is held.
- Clears probes, FSMs (to IDLE), hold counters, pending flags, `rr_ptr` (to 0), the output register and `overrun_out`.
- Reloads the tick counter.

## Timing

- All outputs are registered. Reset values: `event_valid_out=0`, `event_btn_out=0`, `event_long_out=0`, `overrun_out=0`.
- First `tick` occurs `COUNT_PER_PERIOD-1` cycles after the first cycle with `reset_in=1`. Ticks then recur every `COUNT_PER_PERIOD` cycles.
- Post occurs in the tick cycle. The pending flag is visible on the next edge. `event_valid_out` rises 1 cycle later, provided the output register is free: 2 cycles from tick to valid.
- Valid/ready:
  - Outputs are stable while `valid && !ready`.
  - Back-to-back events are allowed, with one accepted per cycle when `ready` is held high.
- Press latency: a press stable from tick k shows the press edge at tick k+1 (pattern 011).
- LONG is posted on the `LONG_PRESS_TICKS`-th tick after the press-edge tick.
- `overrun_out` stays high until reset.

## Structure

- Shared package `btn_pkg`:
  - `typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} btn_state_t`.
  - `typedef struct packed {logic [IDXW-1:0] btn; logic long_press;} btn_event_t`.
  - A `count_per_period(clk_mhz, period_ms)` function.
- Sub-module `btn_classifier`, instantiated once per button: probe shift register, FSM, hold counter, and `post_short` / `post_long` strobes.
- The tick counter, pending flags, round-robin arbiter and output register stay in the top level.

## Test plan

All scenarios use `CLK_MHZ=1`, `PERIOD_MS=1` (tick every 1000 cycles), `LONG_PRESS_TICKS=5`, `NUM_BTNS=4`.

1. **Short press.** Hold `btn_in[2]` high for 3 ticks, then low, with `ready=1`. Expect one event: `btn=2`, `long=0`, valid 2 cycles after the release-detect tick. No further events.
2. **Long press.** Hold `btn_in[1]` for 12 ticks. Expect a single `btn=1`, `long=1` event on the 5th tick after the press edge. No event at release.
3. **Glitch rejection.** Pulse `btn_in[0]` high for 1 tick only, then issue 1-tick low dips during a 3-tick hold. Expect no event for the pulse, and exactly one SHORT for the hold.
4. **Fairness.** With `ready=0`, press buttons 0 to 3 short in the same ticks. Then raise `ready`. Expect the order 0,1,2,3 on consecutive cycles. Repeat with `rr_ptr=2` and expect 2,3,0,1.
5. **Overrun.** With `ready=0`, perform two SHORT presses on button 3. Expect `overrun_out=1` after the second post, and exactly one `btn=3` event once `ready=1`.
6. **Reset mid-operation.** Pull `reset_in` low for 1 cycle during the HELD state and while `valid=1`. Expect all outputs 0 on the next edge, no event from the interrupted press, and the next tick `COUNT_PER_PERIOD-1` cycles after reset release.

Source files
------------

// File: rtl/btn_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and helpers for the button event scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

   // Widest button index the scheduler supports (up to 8 buttons)
   localparam int IDXW = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } btn_state_t;

   typedef struct packed {
      logic [IDXW-1:0] btn;
      logic            long_press;
   } btn_event_t;

   // Number of clock cycles in one debounce sample period
   function automatic int count_per_period(input int clk_mhz, input int period_ms);
      return clk_mhz * period_ms * 1000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_scheduler_if
// Description : Valid/ready event port between the button scheduler and the
//               mode/sequence controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_event_scheduler_if #(
   parameter int NUM_BTNS = 4
);
   localparam int C_BTN_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;

   logic               event_valid_out;
   logic               event_ready_in;
   logic [C_BTN_W-1:0] event_btn_out;
   logic               event_long_out;

   modport master (
      output event_valid_out,
      output event_btn_out,
      output event_long_out,
      input  event_ready_in
   );

   modport slave (
      input  event_valid_out,
      input  event_btn_out,
      input  event_long_out,
      output event_ready_in
   );

endinterface
`default_nettype wire

// File: rtl/btn_event_scheduler_classifier.sv
`default_nettype none
// ============================================================================
// Module      : btn_classifier
// Description : Per-button debounce probe and press/hold classifier. Emits a
//               one-cycle post_short or post_long strobe in a tick cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_classifier
   import btn_pkg::*;
#(
   parameter int LONG_PRESS_TICKS = 100
) (
   input  wire logic clock_in,
   input  wire logic reset_in,
   input  wire logic tick,
   input  wire logic btn,
   output logic      post_short,
   output logic      post_long
);

   localparam int                  C_HOLD_W    = $clog2(LONG_PRESS_TICKS);
   localparam logic [C_HOLD_W-1:0] C_LONG_LAST = C_HOLD_W'(LONG_PRESS_TICKS - 1);

   logic [2:0]          r_probe;
   logic [2:0]          w_probe_nxt;
   logic                w_press_edge;
   logic                w_released;
   btn_state_t          r_state;
   btn_state_t          w_state_nxt;
   logic [C_HOLD_W-1:0] r_hold_cnt;
   logic [C_HOLD_W-1:0] w_hold_nxt;

   // Decisions use the probe as it will look after this tick's shift
   assign w_probe_nxt  = {r_probe[1:0], btn};
   assign w_press_edge = (w_probe_nxt == 3'b011);
   assign w_released   = (w_probe_nxt[1:0] == 2'b00);

   // Probe, state and hold counter registers; everything advances on tick only
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         r_probe    <= 3'b000;
         r_state    <= ST_IDLE;
         r_hold_cnt <= '0;
      end else if (tick) begin
         r_probe    <= w_probe_nxt;
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
      end
   end

   // Next-state and post strobes; LONG fires when the count reaches its last value
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      post_short  = 1'b0;
      post_long   = 1'b0;
      if (tick) begin
         case (r_state)
            ST_IDLE: begin
               if (w_press_edge) begin
                  w_state_nxt = ST_HELD;
                  w_hold_nxt  = '0;
               end
            end
            ST_HELD: begin
               if (w_released) begin
                  post_short  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (r_hold_cnt == C_LONG_LAST) begin
                  post_long   = 1'b1;
                  w_state_nxt = ST_LONG;
               end else begin
                  w_hold_nxt = r_hold_cnt + C_HOLD_W'(1);
               end
            end
            ST_LONG: begin
               if (w_released) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/btn_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_scheduler
// Description : Shared-prescaler button front end. One debounce tick feeds a
//               classifier per button; a round-robin arbiter serialises the
//               SHORT/LONG events onto one valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_event_scheduler
   import btn_pkg::*;
#(
   parameter int NUM_BTNS         = 4,
   parameter int PERIOD_MS        = 10,
   parameter int CLK_MHZ          = 8,
   parameter int LONG_PRESS_TICKS = 100
) (
   input  wire logic                clock_in,
   input  wire logic                reset_in,
   input  wire logic [NUM_BTNS-1:0] btn_in,
   btn_event_scheduler_if.master    ev,
   output logic                     overrun_out
);

   localparam int C_COUNT = count_per_period(CLK_MHZ, PERIOD_MS);
   localparam int C_CNT_W = $clog2(C_COUNT);
   localparam int C_BTN_W = $clog2(NUM_BTNS);

   logic [C_CNT_W-1:0]  r_tick_cnt;
   logic                w_tick;
   logic [NUM_BTNS-1:0] w_post_short;
   logic [NUM_BTNS-1:0] w_post_long;
   logic [NUM_BTNS-1:0] r_pend_short;
   logic [NUM_BTNS-1:0] r_pend_long;
   logic [NUM_BTNS-1:0] w_clr_short;
   logic [NUM_BTNS-1:0] w_clr_long;
   logic                w_overrun_hit;
   logic [C_BTN_W-1:0]  r_rr_ptr;
   logic [C_BTN_W-1:0]  w_winner;
   logic                w_found;
   logic                w_load;
   logic                r_valid;
   logic [C_BTN_W-1:0]  r_btn;
   logic                r_long;

   assign w_tick = (r_tick_cnt == '0);

   // Shared prescaler: counts down and reloads in the tick cycle
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         r_tick_cnt <= C_CNT_W'(C_COUNT - 1);
      end else if (w_tick) begin
         r_tick_cnt <= C_CNT_W'(C_COUNT - 1);
      end else begin
         r_tick_cnt <= r_tick_cnt - C_CNT_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_classifier #(
         .LONG_PRESS_TICKS (LONG_PRESS_TICKS)
      ) u_classifier (
         .clock_in   (clock_in),
         .reset_in   (reset_in),
         .tick       (w_tick),
         .btn        (btn_in[i]),
         .post_short (w_post_short[i]),
         .post_long  (w_post_long[i])
      );
   end

   assign w_load = !r_valid || ev.event_ready_in;

   // Round-robin search from rr_ptr upward; LONG beats SHORT inside one button
   always_comb begin
      w_found     = 1'b0;
      w_winner    = '0;
      w_clr_short = '0;
      w_clr_long  = '0;
      for (int k = 0; k < NUM_BTNS; k++) begin
         int idx;
         idx = (int'(r_rr_ptr) + k) % NUM_BTNS;
         if (!w_found && (r_pend_short[idx] || r_pend_long[idx])) begin
            w_found  = 1'b1;
            w_winner = C_BTN_W'(idx);
         end
      end
      if (w_load && w_found) begin
         if (r_pend_long[w_winner]) begin
            w_clr_long[w_winner] = 1'b1;
         end else begin
            w_clr_short[w_winner] = 1'b1;
         end
      end
   end

   // A post into a flag that stays set loses the event
   assign w_overrun_hit = |((w_post_short & r_pend_short & ~w_clr_short) |
                            (w_post_long  & r_pend_long  & ~w_clr_long));

   // Pending flags: a same-cycle post overrides the arbiter's clear
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         r_pend_short <= '0;
         r_pend_long  <= '0;
         overrun_out  <= 1'b0;
      end else begin
         r_pend_short <= (r_pend_short & ~w_clr_short) | w_post_short;
         r_pend_long  <= (r_pend_long  & ~w_clr_long)  | w_post_long;
         if (w_overrun_hit) begin
            overrun_out <= 1'b1;
         end
      end
   end

   // Output register and round-robin pointer, loaded whenever the slot is free
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         r_valid  <= 1'b0;
         r_btn    <= '0;
         r_long   <= 1'b0;
         r_rr_ptr <= '0;
      end else if (w_load) begin
         if (w_found) begin
            r_valid  <= 1'b1;
            r_btn    <= w_winner;
            r_long   <= r_pend_long[w_winner];
            r_rr_ptr <= (w_winner == C_BTN_W'(NUM_BTNS - 1)) ? '0 : w_winner + C_BTN_W'(1);
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign ev.event_valid_out = r_valid;
   assign ev.event_btn_out   = r_btn;
   assign ev.event_long_out  = r_long;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_scheduler
// Description : Self-checking bench for btn_event_scheduler with a
//               cycle-level behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_scheduler;
   import btn_pkg::*;

   localparam int NB  = 4;
   localparam int CPP = 1000;
   localparam int LPT = 5;

   logic          clock_in = 1'b0;
   logic          reset_in = 1'b0;
   logic [NB-1:0] btn_in   = '0;
   logic          ready    = 1'b1;
   logic          overrun_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   btn_event_t acc_q[$];
   int         acc_cyc[$];

   // reference model state
   int       m_cnt;
   logic [2:0] m_hist [NB];
   bit       m_pressed [NB];
   bit       m_longdone [NB];
   int       m_age [NB];
   bit       m_ps [NB];
   bit       m_pl [NB];
   int       m_rr;
   bit       m_v;
   int       m_btn;
   bit       m_long;
   bit       m_ovr;

   always #5 clock_in = ~clock_in;

   btn_event_scheduler_if #(.NUM_BTNS(NB)) ev ();
   assign ev.event_ready_in = ready;

   btn_event_scheduler #(
      .NUM_BTNS         (NB),
      .PERIOD_MS        (1),
      .CLK_MHZ          (1),
      .LONG_PRESS_TICKS (LPT)
   ) dut (
      .clock_in    (clock_in),
      .reset_in    (reset_in),
      .btn_in      (btn_in),
      .ev          (ev.master),
      .overrun_out (overrun_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = CPP - 1;
      for (int i = 0; i < NB; i++) begin
         m_hist[i] = 3'b000; m_pressed[i] = 0; m_longdone[i] = 0;
         m_age[i] = 0; m_ps[i] = 0; m_pl[i] = 0;
      end
      m_rr = 0; m_v = 0; m_btn = 0; m_long = 0; m_ovr = 0;
   endtask

   // One clock edge of the behavioural model, given the inputs seen at that edge
   task automatic model_edge(input bit rn, input logic [NB-1:0] b, input bit rdy);
      bit tick, found;
      bit post_s [NB], post_l [NB], clr_s [NB], clr_l [NB];
      int wsel;
      if (!rn) begin
         model_reset();
         return;
      end
      tick  = (m_cnt == 0);
      m_cnt = tick ? CPP - 1 : m_cnt - 1;
      for (int i = 0; i < NB; i++) begin
         post_s[i] = 0; post_l[i] = 0; clr_s[i] = 0; clr_l[i] = 0;
      end
      if (tick) begin
         for (int i = 0; i < NB; i++) begin
            m_hist[i] = {m_hist[i][1:0], b[i]};
            if (!m_pressed[i]) begin
               if (m_hist[i] == 3'b011) begin
                  m_pressed[i] = 1; m_age[i] = 0; m_longdone[i] = 0;
               end
            end else if (m_hist[i][1:0] == 2'b00) begin
               if (!m_longdone[i]) post_s[i] = 1;
               m_pressed[i] = 0;
            end else if (!m_longdone[i]) begin
               m_age[i]++;
               if (m_age[i] == LPT) begin
                  post_l[i] = 1; m_longdone[i] = 1;
               end
            end
         end
      end
      if (!m_v || rdy) begin
         found = 0; wsel = 0;
         for (int k = 0; k < NB; k++) begin
            int w;
            w = (m_rr + k) % NB;
            if (!found && (m_ps[w] || m_pl[w])) begin
               found = 1; wsel = w;
            end
         end
         if (found) begin
            m_v = 1; m_btn = wsel; m_long = m_pl[wsel];
            if (m_pl[wsel]) clr_l[wsel] = 1; else clr_s[wsel] = 1;
            m_rr = (wsel + 1) % NB;
         end else begin
            m_v = 0;
         end
      end
      for (int i = 0; i < NB; i++) begin
         if ((post_s[i] && m_ps[i] && !clr_s[i]) || (post_l[i] && m_pl[i] && !clr_l[i])) m_ovr = 1;
         m_ps[i] = (m_ps[i] && !clr_s[i]) || post_s[i];
         m_pl[i] = (m_pl[i] && !clr_l[i]) || post_l[i];
      end
   endtask

   // One clock cycle: log handshakes, advance model, compare 1 ns after the edge
   task automatic step();
      logic [NB-1:0] b;
      bit r, rn;
      btn_event_t e;
      b = btn_in; r = ready; rn = reset_in;
      if (rn && ev.event_valid_out === 1'b1 && r) begin
         e.btn        = IDXW'(ev.event_btn_out);
         e.long_press = ev.event_long_out;
         acc_q.push_back(e);
         acc_cyc.push_back(cyc);
      end
      @(posedge clock_in);
      cyc++;
      model_edge(rn, b, r);
      #1;
      chk("valid", ev.event_valid_out, m_v);
      chk("overrun", overrun_out, m_ovr);
      if (m_v) begin
         chk("btn", ev.event_btn_out, m_btn);
         chk("long", ev.event_long_out, m_long);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_t(input int n);
      run(n * CPP);
   endtask

   task automatic run_rand(input int n);
      for (int i = 0; i < n; i++) begin
         ready = 1'($urandom_range(0, 1));
         step();
      end
   endtask

   task automatic pulse_reset();
      reset_in = 1'b0;
      step();
      reset_in = 1'b1;
   endtask

   task automatic check_order(input string tag, input int s0, input int ord [4]);
      chk({tag, "_count"}, acc_q.size() - s0, 4);
      if (acc_q.size() >= s0 + 4) begin
         for (int k = 0; k < 4; k++) begin
            chk({tag, "_btn"}, acc_q[s0 + k].btn, ord[k]);
            chk({tag, "_gap"}, acc_cyc[s0 + k] - acc_cyc[s0], k);
         end
      end
   endtask

   initial begin
      int s0;
      int n3;
      int ord_a [4];
      int ord_b [4];
      ord_a = '{0, 1, 2, 3};
      ord_b = '{2, 3, 0, 1};
      model_reset();

      // reset state
      run(3);
      chk("rst_valid", ev.event_valid_out, 0);
      chk("rst_btn", ev.event_btn_out, 0);
      chk("rst_long", ev.event_long_out, 0);
      chk("rst_overrun", overrun_out, 0);
      reset_in = 1'b1;
      run(500);

      // short press on button 2
      s0 = acc_q.size();
      btn_in = 4'b0100; run_t(3);
      btn_in = 4'b0000; run_t(2);
      chk("short_count", acc_q.size() - s0, 1);
      if (acc_q.size() > s0) begin
         chk("short_btn", acc_q[s0].btn, 2);
         chk("short_long", acc_q[s0].long_press, 0);
      end

      // long press on button 1, nothing at release
      s0 = acc_q.size();
      btn_in = 4'b0010; run_t(12);
      btn_in = 4'b0000; run_t(2);
      chk("long_count", acc_q.size() - s0, 1);
      if (acc_q.size() > s0) begin
         chk("long_btn", acc_q[s0].btn, 1);
         chk("long_long", acc_q[s0].long_press, 1);
      end

      // glitch pulse, then a hold with a one-tick dip
      s0 = acc_q.size();
      btn_in = 4'b0001; run_t(1);
      btn_in = 4'b0000; run_t(2);
      chk("glitch_count", acc_q.size() - s0, 0);
      btn_in = 4'b0001; run_t(2);
      btn_in = 4'b0000; run_t(1);
      btn_in = 4'b0001; run_t(1);
      btn_in = 4'b0000; run_t(2);
      chk("dip_count", acc_q.size() - s0, 1);
      if (acc_q.size() > s0) begin
         chk("dip_btn", acc_q[s0].btn, 0);
         chk("dip_long", acc_q[s0].long_press, 0);
      end

      // fairness from rr_ptr = 0
      pulse_reset();
      run(500);
      ready = 1'b0;
      btn_in = 4'b1111; run_t(2);
      btn_in = 4'b0000; run_t(2);
      s0 = acc_q.size();
      ready = 1'b1; run(10);
      check_order("rr0", s0, ord_a);
      // one event on button 1 moves rr_ptr to 2
      btn_in = 4'b0010; run_t(2);
      btn_in = 4'b0000; run_t(2);
      ready = 1'b0;
      btn_in = 4'b1111; run_t(2);
      btn_in = 4'b0000; run_t(2);
      s0 = acc_q.size();
      ready = 1'b1; run(10);
      check_order("rr2", s0, ord_b);

      // overrun: output slot blocked, button 3 posts twice
      ready = 1'b0;
      s0 = acc_q.size();
      btn_in = 4'b0001; run_t(2);
      btn_in = 4'b0000; run_t(2);
      btn_in = 4'b1000; run_t(2);
      btn_in = 4'b0000; run_t(2);
      chk("ovr_before", overrun_out, 0);
      btn_in = 4'b1000; run_t(2);
      btn_in = 4'b0000; run_t(2);
      chk("ovr_after", overrun_out, 1);
      ready = 1'b1; run(10);
      n3 = 0;
      for (int k = s0; k < acc_q.size(); k++) if (acc_q[k].btn == 3) n3++;
      chk("ovr_btn3_count", n3, 1);
      chk("ovr_total_count", acc_q.size() - s0, 2);

      // reset while an event is held and button 2 is in HELD
      ready = 1'b0;
      btn_in = 4'b0010; run_t(2);
      btn_in = 4'b0000; run_t(2);
      btn_in = 4'b0100; run_t(3);
      chk("mid_valid_before", ev.event_valid_out, 1);
      reset_in = 1'b0;
      step();
      reset_in = 1'b1;
      btn_in = 4'b0000;
      chk("mid_rst_valid", ev.event_valid_out, 0);
      chk("mid_rst_btn", ev.event_btn_out, 0);
      chk("mid_rst_long", ev.event_long_out, 0);
      chk("mid_rst_overrun", overrun_out, 0);
      s0 = acc_q.size();
      run(500);
      ready = 1'b1; run_t(3);
      chk("mid_no_event", acc_q.size() - s0, 0);

      // random buttons and ready against the model
      for (int t = 0; t < 6; t++) begin
         btn_in = NB'($urandom_range(0, 15));
         run_rand(CPP);
      end
      btn_in = '0;
      ready  = 1'b1;
      run_t(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
